// File: rtl/serial_word_deserializer_if.sv
// Valid/ready word port for serial_word_deserializer.
// The master side (the deserializer) drives data_out/valid_out and the consumer drives ready_in.
interface serial_word_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ready_in;

    modport master (output data_out, output valid_out, input ready_in);
    modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/serial_word_deserializer.sv
// Collects clk_en-qualified serial bits into WIDTH-bit words, aligned on sync_in.
// Completed words pass through a 2-entry buffer to a valid/ready port.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_HUNT  | waiting for clk_en && sync_in; all other bits are ignored
//   ST_SHIFT | capturing one bit per clk_en; a word completes at bit WIDTH-1
module serial_word_deserializer #(
    parameter int WIDTH        = 8,
    parameter int MSB_FIRST    = 1,
    parameter int REQUIRE_SYNC = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         clk_en,
    input  logic                         serial_in,
    input  logic                         sync_in,
    serial_word_deserializer_if.master   out_if,
    output logic [4:0]                   bit_idx_out,
    output logic                         align_err_out,
    output logic                         overflow_out
);

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = (REQUIRE_SYNC != 0) ? ST_HUNT : ST_SHIFT;
    localparam logic [4:0] LAST_IDX    = 5'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic             align_err_q, align_err_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    logic             capture;
    logic             restart;
    logic             misalign;
    logic [4:0]       idx_cur;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shift_new;
    logic             word_done;
    logic             pop;

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:  if (clk_en && sync_in) state_d = ST_SHIFT;
            ST_SHIFT: state_d = ST_SHIFT;
            default:  state_d = RESET_STATE;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        capture  = 1'b0;
        restart  = 1'b0;
        misalign = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (clk_en && sync_in) begin
                    capture = 1'b1;
                    restart = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (clk_en) begin
                    capture = 1'b1;
                    if (sync_in) begin
                        restart  = 1'b1;
                        misalign = (bit_idx_q != 5'd0);
                    end
                end
            end
            default: ;
        endcase
    end

    // A restart drops any partial word: the sync bit becomes bit 0 of a fresh word.
    always_comb begin
        idx_cur    = restart ? 5'd0 : bit_idx_q;
        shift_base = restart ? '0 : shift_q;
        shift_new  = (MSB_FIRST != 0) ? {shift_base[WIDTH-2:0], serial_in}
                                      : {serial_in, shift_base[WIDTH-1:1]};
        word_done  = capture && (idx_cur == LAST_IDX);
        pop        = (count_q != 2'd0) && out_if.ready_in;

        shift_d     = capture ? shift_new : shift_q;
        bit_idx_d   = bit_idx_q;
        if (capture) begin
            bit_idx_d = word_done ? 5'd0 : idx_cur + 5'd1;
        end
        align_err_d = misalign;
        overflow_d  = overflow_q;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({word_done, pop})
            2'b10: begin
                case (count_q)
                    2'd0: begin
                        head_d  = shift_new;
                        count_d = 2'd1;
                    end
                    2'd1: begin
                        tail_d  = shift_new;
                        count_d = 2'd2;
                    end
                    default: overflow_d = 1'b1;
                endcase
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            // Pop and push on the same edge: occupancy is unchanged, nothing lost.
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = shift_new;
                end else begin
                    head_d = shift_new;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_q     <= '0;
            bit_idx_q   <= 5'd0;
            align_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
        end else begin
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            align_err_q <= align_err_d;
            overflow_q  <= overflow_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    assign out_if.data_out  = head_q;
    assign out_if.valid_out = (count_q != 2'd0);
    assign bit_idx_out      = bit_idx_q;
    assign align_err_out    = align_err_q;
    assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench for serial_word_deserializer (WIDTH=8, MSB first, sync required).
module tb_serial_word_deserializer;
    localparam int WIDTH = 8;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       clk_en = 1'b0;
    logic       serial_in = 1'b0;
    logic       sync_in = 1'b0;
    logic [4:0] bit_idx_out;
    logic       align_err_out;
    logic       overflow_out;

    serial_word_deserializer_if #(.WIDTH(WIDTH)) bus ();

    serial_word_deserializer #(
        .WIDTH(WIDTH), .MSB_FIRST(1), .REQUIRE_SYNC(1)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .clk_en(clk_en),
        .serial_in(serial_in),
        .sync_in(sync_in),
        .out_if(bus.master),
        .bit_idx_out(bit_idx_out),
        .align_err_out(align_err_out),
        .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;
    int rx_count = 0;
    int tx_count = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs are presented, one rising edge passes, and we return 1 time unit after it.
    task automatic cycle(input logic b, input logic s, input logic e);
        serial_in = b;
        sync_in   = s;
        clk_en    = e;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic with_sync);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cycle(w[i], with_sync && (i == WIDTH - 1), 1'b1);
        end
        clk_en  = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic expect_word(input logic [WIDTH-1:0] w);
        exp_q.push_back(w);
        tx_count++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        rst_in = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        rst_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_data"}, 32'(bus.data_out), 32'd0);
        check_val({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
        check_val({tag, "_idx"}, 32'(bit_idx_out), 32'd0);
        check_val({tag, "_aerr"}, 32'(align_err_out), 32'd0);
        check_val({tag, "_ovf"}, 32'(overflow_out), 32'd0);
    endtask

    always @(negedge clk_in) begin
        if (!rst_in && bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_word", 32'(exp_q.size()), 32'd1);
            end else begin
                check_val("word", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
            rx_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w;
        bus.ready_in = 1'b0;

        // 1: reset values, then a synced A5 and its one-cycle latency
        do_reset();
        check_reset_outputs("rst1");
        bus.ready_in = 1'b1;
        expect_word(8'hA5);
        send_word(8'hA5, 1'b1);
        check_val("t1_valid", 32'(bus.valid_out), 32'd1);
        check_val("t1_data", 32'(bus.data_out), 32'hA5);
        idle(1);
        check_val("t1_valid_after_pop", 32'(bus.valid_out), 32'd0);
        check_val("t1_data_hold", 32'(bus.data_out), 32'hA5);

        // 2: hunt ignores unsynced bits
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(i[0], 1'b0, 1'b1);
            check_val("t2_hunt_idx", 32'(bit_idx_out), 32'd0);
        end
        check_val("t2_hunt_valid", 32'(bus.valid_out), 32'd0);
        expect_word(8'h3C);
        send_word(8'h3C, 1'b1);
        idle(3);
        check_val("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: clk_en gaps hold bit index
        w = 8'hF0;
        expect_word(w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cycle(w[i], (i == WIDTH - 1), 1'b1);
            check_val("t3_idx_en", 32'(bit_idx_out), 32'((WIDTH - i) % WIDTH));
            cycle(~w[i], 1'b1, 1'b0);
            check_val("t3_idx_hold", 32'(bit_idx_out), 32'((WIDTH - i) % WIDTH));
        end
        idle(3);
        check_val("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: stalled consumer, third word overflows
        bus.ready_in = 1'b0;
        expect_word(8'h11);
        expect_word(8'h22);
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b1);
        check_val("t4_ovf_before", 32'(overflow_out), 32'd0);
        send_word(8'h33, 1'b1);
        check_val("t4_ovf_after", 32'(overflow_out), 32'd1);
        check_val("t4_head_stable", 32'(bus.data_out), 32'h11);
        idle(2);
        check_val("t4_head_stall", 32'(bus.data_out), 32'h11);
        bus.ready_in = 1'b1;
        idle(4);
        check_val("t4_drained_valid", 32'(bus.valid_out), 32'd0);
        check_val("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        check_val("t4_ovf_sticky", 32'(overflow_out), 32'd1);

        // 5: mid-word sync, then full buffer with pop and push on one edge
        do_reset();
        check_val("t5_ovf_cleared", 32'(overflow_out), 32'd0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        check_val("t5_idx3", 32'(bit_idx_out), 32'd3);
        check_val("t5_no_err", 32'(align_err_out), 32'd0);
        w = 8'h55;
        expect_word(w);
        cycle(w[7], 1'b1, 1'b1);
        check_val("t5_aerr_pulse", 32'(align_err_out), 32'd1);
        check_val("t5_idx_restart", 32'(bit_idx_out), 32'd1);
        cycle(w[6], 1'b0, 1'b1);
        check_val("t5_aerr_clear", 32'(align_err_out), 32'd0);
        for (int i = 5; i >= 0; i--) cycle(w[i], 1'b0, 1'b1);
        idle(2);
        check_val("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        bus.ready_in = 1'b0;
        expect_word(8'hAA);
        expect_word(8'hBB);
        expect_word(8'hCC);
        send_word(8'hAA, 1'b1);
        send_word(8'hBB, 1'b1);
        w = 8'hCC;
        for (int i = WIDTH - 1; i >= 1; i--) cycle(w[i], (i == WIDTH - 1), 1'b1);
        bus.ready_in = 1'b1;
        cycle(w[0], 1'b0, 1'b1);
        check_val("t5_full_push_ovf", 32'(overflow_out), 32'd0);
        check_val("t5_full_push_valid", 32'(bus.valid_out), 32'd1);
        idle(4);
        check_val("t5_stream_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset mid-word with a word buffered
        bus.ready_in = 1'b0;
        send_word(8'h77, 1'b1);
        check_val("t6_buffered", 32'(bus.valid_out), 32'd1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        check_val("t6_idx4", 32'(bit_idx_out), 32'd4);
        do_reset();
        check_reset_outputs("rst6");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1);
            check_val("t6_hunt_idx", 32'(bit_idx_out), 32'd0);
        end
        bus.ready_in = 1'b1;
        expect_word(8'h5A);
        send_word(8'h5A, 1'b1);
        idle(3);
        check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_val("final_rx_total", 32'(rx_count), 32'(tx_count));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
